// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - FIFO-buffered fixed-frame PWM audio output with sample-rate strobe
module pwm_audio_out #(
    parameter int PWM_BITS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    input  logic signed [15:0]                 data_in,
    input  logic                               clear_flags,
    output logic                               sample_tick,
    output logic                               pwm_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               underflow,
    output logic                               overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] code;
    logic [PWM_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                boundary;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;

    // Offset-binary code from the top PWM_BITS of the sample; truncation only.
    assign code     = {~data_in[15], data_in[14 -: PWM_BITS-1]};
    assign boundary = &pwm_cnt;
    assign empty    = (fifo_level == '0);
    assign full     = (fifo_level == LW'(FIFO_DEPTH));
    assign pop      = boundary & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push     = valid_in & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt     <= '0;
            duty        <= {1'b1, {(PWM_BITS-1){1'b0}}};
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            sample_tick <= 1'b0;
            pwm_out     <= 1'b0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
            sample_tick <= boundary;
            pwm_out     <= (pwm_cnt < duty);
            if (pop) begin
                duty   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            // Set events take priority over a coincident clear.
            underflow <= (boundary & empty) | (underflow & ~clear_flags);
            overflow  <= (valid_in & full & ~pop) | (overflow & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb/tb_pwm_audio_out.sv - randomized scoreboard bench for pwm_audio_out
module tb_pwm_audio_out;

    localparam int DEPTH = 4;
    localparam int FRAME = 1024;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic signed [15:0] data_in;
    logic               clear_flags;
    logic               sample_tick;
    logic               pwm_out;
    logic [2:0]         fifo_level;
    logic               underflow;
    logic               overflow;

    int passed = 0;
    int total  = 0;

    int q[$];
    int sb[$];
    int m_duty;
    int m_cnt;
    bit m_uf;
    bit m_of;
    bit m_tick;
    int hi_cnt = 0;
    int frames_checked = 0;

    pwm_audio_out #(.PWM_BITS(10), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .clear_flags (clear_flags),
        .sample_tick (sample_tick),
        .pwm_out     (pwm_out),
        .fifo_level  (fifo_level),
        .underflow   (underflow),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic int to_code(logic signed [15:0] s);
        return (int'(s) + 32768) / 64;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        sb.delete();
        m_duty = 512;
        m_cnt  = 0;
        m_uf   = 0;
        m_of   = 0;
        m_tick = 0;
        sb.push_back(m_duty);
    endtask

    // One clock: check DUT state against the model, drive inputs, advance the model.
    task automatic step(bit v, logic signed [15:0] d, bit clr);
        bit b;
        bit uf_set;
        bit of_set;
        @(negedge clk);
        check("fifo_level", int'(fifo_level), q.size());
        check("underflow", int'(underflow), int'(m_uf));
        check("overflow", int'(overflow), int'(m_of));
        check("sample_tick", int'(sample_tick), int'(m_tick));
        valid_in    = v;
        data_in     = d;
        clear_flags = clr;
        b      = (m_cnt == FRAME - 1);
        uf_set = 0;
        of_set = 0;
        if (b) begin
            if (q.size() > 0) m_duty = q.pop_front();
            else uf_set = 1;
            sb.push_back(m_duty);
        end
        if (v) begin
            if (q.size() < DEPTH) q.push_back(to_code(d));
            else of_set = 1;
        end
        m_uf   = uf_set | (m_uf & !clr);
        m_of   = of_set | (m_of & !clr);
        m_tick = b;
        m_cnt  = (m_cnt + 1) % FRAME;
    endtask

    // Monitor: count high cycles per frame, compare against the duty expected for that frame.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hi_cnt = 0;
            end else begin
                hi_cnt += int'(pwm_out);
                if (sample_tick) begin
                    check("sb_nonempty", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) check("frame_high_count", hi_cnt, sb.pop_front());
                    frames_checked++;
                    hi_cnt = 0;
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        clear_flags = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 300; i++) step(i == 50 || i == 51, 16'sh1234, 0);

        @(posedge clk);
        #2 rst = 1'b1;
        valid_in = 1'b0;
        #1;
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_sample_tick", int'(sample_tick), 0);
        check("rst_underflow", int'(underflow), 0);
        check("rst_overflow", int'(overflow), 0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;

        repeat (10) step(0, 16'sh0000, 0);
        step(1, 16'sh7FFF, 0);
        step(1, 16'sh8000, 0);
        step(1, 16'sh0000, 0);
        repeat (6 * FRAME) step(0, 16'sh0000, 0);
        step(0, 16'sh0000, 1);
        repeat (2) step(0, 16'sh0000, 0);

        for (int i = 0; i < 6; i++) step(1, 16'($urandom), 0);
        step(0, 16'sh0000, 1);
        while (m_cnt != FRAME - 1) step(0, 16'sh0000, 0);
        step(1, 16'($urandom), 0);
        repeat (FRAME + 10) step(0, 16'sh0000, 0);

        for (int f = 0; f < 50; f++) begin
            int r;
            r = $urandom_range(0, 3);
            for (int c = 0; c < FRAME; c++)
                step($urandom_range(0, 1023) < r, 16'($urandom), $urandom_range(0, 4095) == 0);
        end
        step(0, 16'sh0000, 0);

        check("frames_checked_min", int'(frames_checked >= 50), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
